// File: rtl/lc3_execute_pipe_if.sv
// Handshaked bus between decode/regfile, the LC-3 execute stage and memory-access.
// The master drives instructions in and accepts results; the slave is the execute stage.
interface lc3_execute_pipe_if #(
    parameter int DW      = 16,
    parameter int NUM_BYP = 2
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            alu_op;
    logic [1:0]            pcsel1;
    logic                  pcsel2;
    logic                  op2sel;
    logic [1:0]            W_Control_in;
    logic                  Mem_Control_in;
    logic [15:0]           IR;
    logic [DW-1:0]         npc_in;
    logic [DW-1:0]         VSR1;
    logic [DW-1:0]         VSR2;
    logic [NUM_BYP*DW-1:0] byp_val;
    logic [NUM_BYP-1:0]    byp_hit1;
    logic [NUM_BYP-1:0]    byp_hit2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         aluout;
    logic [DW-1:0]         pcout;
    logic [DW-1:0]         M_Data;
    logic [1:0]            W_Control_out;
    logic                  Mem_Control_out;
    logic [2:0]            dr;
    logic [2:0]            NZP;
    logic [15:0]           IR_Exec;
    logic                  busy;

    modport master (
        output flush, in_valid, alu_op, pcsel1, pcsel2, op2sel, W_Control_in,
               Mem_Control_in, IR, npc_in, VSR1, VSR2, byp_val, byp_hit1, byp_hit2,
               out_ready,
        input  in_ready, out_valid, aluout, pcout, M_Data, W_Control_out,
               Mem_Control_out, dr, NZP, IR_Exec, busy
    );

    modport slave (
        input  flush, in_valid, alu_op, pcsel1, pcsel2, op2sel, W_Control_in,
               Mem_Control_in, IR, npc_in, VSR1, VSR2, byp_val, byp_hit1, byp_hit2,
               out_ready,
        output in_ready, out_valid, aluout, pcout, M_Data, W_Control_out,
               Mem_Control_out, dr, NZP, IR_Exec, busy
    );
endinterface

// File: rtl/lc3_execute_pipe.sv
// LC-3 execute stage with valid/ready handshake, priority bypass network,
// iterative radix-2 multiplier and synchronous branch-redirect flush.
module lc3_execute_pipe #(
    parameter int DW      = 16,
    parameter int NUM_BYP = 2,
    parameter int MUL_EN  = 1
) (
    input logic               clk,
    input logic               rst,
    lc3_execute_pipe_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t state_p0, state_nxt;
    logic   busy_c;

    logic signed [DW-1:0] src1, src2, imm5_x, pc_off, pc_base, pc_sum, alu_res;
    logic        [DW-1:0] mdata_c, acc_nxt;
    logic                 accept, is_mul, load_single, mul_last, mul_done;

    // multiplier operands plus the fields that travel with a multiply
    logic [DW-1:0] mcand_p0, mplier_p0, acc_p0, pcout_p0, mdata_p0;
    logic [CW-1:0] cnt_p0;
    logic [15:0]   ir_p0;
    logic [1:0]    wctl_p0;
    logic          mctl_p0;

    logic          vld_p1;
    logic [DW-1:0] aluout_p1, pcout_p1, mdata_p1;
    logic [1:0]    wctl_p1;
    logic          mctl_p1;
    logic [2:0]    dr_p1, nzp_p1;
    logic [15:0]   ir_p1;

    function automatic logic [2:0] nzp_of(input logic [15:0] ir);
        return (ir[15:12] == 4'b0000) ? ir[11:9] : 3'b000;
    endfunction

    function automatic logic is_store(input logic [3:0] opc);
        return (opc == 4'b0011) || (opc == 4'b0111) || (opc == 4'b1011);
    endfunction

    assign bus.in_ready = !busy_c && (!vld_p1 || bus.out_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = (MUL_EN != 0) && (bus.alu_op == 3'd4);
    assign load_single  = accept && !is_mul;
    assign mul_last     = (cnt_p0 == CW'(DW - 1));
    assign mul_done     = busy_c && mul_last && !bus.flush;
    assign acc_nxt      = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

    // Operand resolution: lowest-index bypass hit wins, so scan downward.
    always_comb begin
        imm5_x = {{(DW-5){bus.IR[4]}}, bus.IR[4:0]};
        src1   = bus.VSR1;
        src2   = bus.op2sel ? bus.VSR2 : imm5_x;
        for (int k = NUM_BYP - 1; k >= 0; k--) begin
            if (bus.byp_hit1[k]) src1 = bus.byp_val[k*DW +: DW];
            if (bus.byp_hit2[k]) src2 = bus.byp_val[k*DW +: DW];
        end
    end

    always_comb begin
        case (bus.pcsel1)
            2'd0:    pc_off = {{(DW-11){bus.IR[10]}}, bus.IR[10:0]};
            2'd1:    pc_off = {{(DW-9){bus.IR[8]}}, bus.IR[8:0]};
            2'd2:    pc_off = {{(DW-6){bus.IR[5]}}, bus.IR[5:0]};
            default: pc_off = '0;
        endcase
        pc_base = bus.pcsel2 ? bus.npc_in : src1;
        pc_sum  = pc_off + pc_base;
        mdata_c = is_store(bus.IR[15:12]) ? src1 : '0;
        case (bus.alu_op)
            3'd1:    alu_res = src1 & src2;
            3'd2:    alu_res = ~src1;
            3'd3:    alu_res = src2;
            default: alu_res = src1 + src2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_p0 <= S_IDLE;
        else     state_p0 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p0;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_p0)
                S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
                S_MUL:   if (mul_last)         state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_c   = (state_p0 == S_MUL);
        bus.busy = busy_c;
    end

    // Stage p0: capture a multiply, then one shift-add step per cycle.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand_p0  <= src1;
            mplier_p0 <= src2;
            acc_p0    <= '0;
            cnt_p0    <= '0;
            pcout_p0  <= pc_sum;
            mdata_p0  <= mdata_c;
            ir_p0     <= bus.IR;
            wctl_p0   <= bus.W_Control_in;
            mctl_p0   <= bus.Mem_Control_in;
        end else if (busy_c) begin
            acc_p0    <= acc_nxt;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            cnt_p0    <= cnt_p0 + 1'b1;
        end
    end

    // Stage p1: output register, held under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            aluout_p1 <= '0;
            pcout_p1  <= '0;
            mdata_p1  <= '0;
            wctl_p1   <= '0;
            mctl_p1   <= 1'b0;
            dr_p1     <= '0;
            nzp_p1    <= '0;
            ir_p1     <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
            nzp_p1 <= '0;
        end else if (load_single) begin
            vld_p1    <= 1'b1;
            aluout_p1 <= alu_res;
            pcout_p1  <= pc_sum;
            mdata_p1  <= mdata_c;
            wctl_p1   <= bus.W_Control_in;
            mctl_p1   <= bus.Mem_Control_in;
            dr_p1     <= bus.IR[11:9];
            nzp_p1    <= nzp_of(bus.IR);
            ir_p1     <= bus.IR;
        end else if (mul_done) begin
            vld_p1    <= 1'b1;
            aluout_p1 <= acc_nxt;
            pcout_p1  <= pcout_p0;
            mdata_p1  <= mdata_p0;
            wctl_p1   <= wctl_p0;
            mctl_p1   <= mctl_p0;
            dr_p1     <= ir_p0[11:9];
            nzp_p1    <= nzp_of(ir_p0);
            ir_p1     <= ir_p0;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
            nzp_p1 <= '0;
        end
    end

    assign bus.out_valid       = vld_p1;
    assign bus.aluout          = aluout_p1;
    assign bus.pcout           = pcout_p1;
    assign bus.M_Data          = mdata_p1;
    assign bus.W_Control_out   = wctl_p1;
    assign bus.Mem_Control_out = mctl_p1;
    assign bus.dr              = dr_p1;
    assign bus.NZP             = nzp_p1;
    assign bus.IR_Exec         = ir_p1;
endmodule
